time_set_ctrl: RTL and testbench

//  Button-driven time-setting controller. It sits in front of the four BCD digit registers
//  (hour tens/units, minute tens/units) and produces their set/load values.
//  It captures the current time into an edit buffer and steps the user through each digit.

---
 rtl/time_set_pkg.sv | 39 +++
 rtl/idle_timer.sv | 37 +++
 rtl/time_set_ctrl.sv | 169 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and digit limits for the time-setting controller.
// Also holds the BCD wrap-increment helpers used by the edit buffer.
package time_set_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_HT,
    S_EDIT_HU,
    S_EDIT_MT,
    S_EDIT_MU,
    S_COMMIT
  } ts_state_t;

  localparam logic [3:0] HR_T_MAX       = 4'd2;
  localparam logic [3:0] HR_U_MAX       = 4'd9;
  localparam logic [3:0] HR_U_MAX_AT_2X = 4'd3;
  localparam logic [3:0] MIN_T_MAX      = 4'd5;
  localparam logic [3:0] MIN_U_MAX      = 4'd9;

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
  } ts_buf_t;

  // Anything at or above the limit (including junk capture) wraps to 0.
  function automatic logic [3:0] wrap_inc(
    input logic [3:0] d,
    input logic [3:0] max
  );
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] hr_u_limit(input logic [3:0] hr_t);
    return (hr_t >= HR_T_MAX) ? HR_U_MAX_AT_2X : HR_U_MAX;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Inactivity timer for the edit session.
// Emits a one-cycle expired pulse after TIMEOUT_CYCLES running cycles without clr.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    expired = run && !clr && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clr || !run || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: captures the current time,
// steps through each BCD digit with 24-hour wrap, and strobes the result out.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_btn,
  input  logic       up_btn,
  input  logic       cancel_btn,
  input  logic [3:0] cur_hr_T,
  input  logic [3:0] cur_hr_U,
  input  logic [3:0] cur_min_T,
  input  logic [3:0] cur_min_U,
  output logic       set_time,
  output logic [3:0] new_hr_T,
  output logic [3:0] new_hr_U,
  output logic [3:0] new_min_T,
  output logic [3:0] new_min_U,
  output logic       editing,
  output logic [1:0] sel,
  output logic [3:0] disp_hr_T,
  output logic [3:0] disp_hr_U,
  output logic [3:0] disp_min_T,
  output logic [3:0] disp_min_U
);

  ts_state_t state_q;
  ts_state_t state_d;
  ts_buf_t   buf_q;
  ts_buf_t   buf_d;

  logic btn_any;
  logic inc;
  logic expired;

  assign btn_any = enter_btn | up_btn | cancel_btn;
  // Cancel beats enter beats up; only one action per cycle.
  assign inc = up_btn & ~enter_btn & ~cancel_btn;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (btn_any),
    .run    (editing),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (enter_btn) begin
          buf_d.hr_t  = cur_hr_T;
          buf_d.hr_u  = cur_hr_U;
          buf_d.min_t = cur_min_T;
          buf_d.min_u = cur_min_U;
          state_d     = S_EDIT_HT;
        end
      end
      S_EDIT_HT: begin
        if (cancel_btn || expired) begin
          state_d = S_IDLE;
        end else if (enter_btn) begin
          state_d = S_EDIT_HU;
        end else if (inc) begin
          buf_d.hr_t = wrap_inc(buf_q.hr_t, HR_T_MAX);
          // Stepping into the 20s must not leave an illegal 24..29.
          if (buf_d.hr_t == HR_T_MAX &&
              buf_q.hr_u > HR_U_MAX_AT_2X) begin
            buf_d.hr_u = HR_U_MAX_AT_2X;
          end
        end
      end
      S_EDIT_HU: begin
        if (cancel_btn || expired) begin
          state_d = S_IDLE;
        end else if (enter_btn) begin
          state_d = S_EDIT_MT;
        end else if (inc) begin
          buf_d.hr_u = wrap_inc(buf_q.hr_u,
                                hr_u_limit(buf_q.hr_t));
        end
      end
      S_EDIT_MT: begin
        if (cancel_btn || expired) begin
          state_d = S_IDLE;
        end else if (enter_btn) begin
          state_d = S_EDIT_MU;
        end else if (inc) begin
          buf_d.min_t = wrap_inc(buf_q.min_t, MIN_T_MAX);
        end
      end
      S_EDIT_MU: begin
        if (cancel_btn || expired) begin
          state_d = S_IDLE;
        end else if (enter_btn) begin
          state_d = S_COMMIT;
        end else if (inc) begin
          buf_d.min_u = wrap_inc(buf_q.min_u, MIN_U_MAX);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    editing  = 1'b0;
    sel      = 2'd0;
    set_time = 1'b0;
    unique case (state_q)
      S_EDIT_HT: begin
        editing = 1'b1;
        sel     = 2'd0;
      end
      S_EDIT_HU: begin
        editing = 1'b1;
        sel     = 2'd1;
      end
      S_EDIT_MT: begin
        editing = 1'b1;
        sel     = 2'd2;
      end
      S_EDIT_MU: begin
        editing = 1'b1;
        sel     = 2'd3;
      end
      S_COMMIT: begin
        set_time = 1'b1;
      end
      default: begin
        editing = 1'b0;
      end
    endcase
  end

  assign new_hr_T  = buf_q.hr_t;
  assign new_hr_U  = buf_q.hr_u;
  assign new_min_T = buf_q.min_t;
  assign new_min_U = buf_q.min_u;

  assign disp_hr_T  = editing ? buf_q.hr_t  : cur_hr_T;
  assign disp_hr_U  = editing ? buf_q.hr_u  : cur_hr_U;
  assign disp_min_T = editing ? buf_q.min_t : cur_min_T;
  assign disp_min_U = editing ? buf_q.min_u : cur_min_U;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: digit-edit vector table,
// commit scoreboard, and hand sequences for cancel/priority/timeout/reset.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter_btn;
  logic       up_btn;
  logic       cancel_btn;
  logic [3:0] cur_hr_T;
  logic [3:0] cur_hr_U;
  logic [3:0] cur_min_T;
  logic [3:0] cur_min_U;
  logic       set_time;
  logic [3:0] new_hr_T;
  logic [3:0] new_hr_U;
  logic [3:0] new_min_T;
  logic [3:0] new_min_U;
  logic       editing;
  logic [1:0] sel;
  logic [3:0] disp_hr_T;
  logic [3:0] disp_hr_U;
  logic [3:0] disp_min_T;
  logic [3:0] disp_min_U;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] cur;
    int          n_ht;
    int          n_hu;
    int          n_mt;
    int          n_mu;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  wire [15:0] new_w  = {new_hr_T, new_hr_U, new_min_T, new_min_U};
  wire [15:0] disp_w = {disp_hr_T, disp_hr_U, disp_min_T, disp_min_U};

  time_set_ctrl #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enter_btn (enter_btn),
    .up_btn    (up_btn),
    .cancel_btn(cancel_btn),
    .cur_hr_T  (cur_hr_T),
    .cur_hr_U  (cur_hr_U),
    .cur_min_T (cur_min_T),
    .cur_min_U (cur_min_U),
    .set_time  (set_time),
    .new_hr_T  (new_hr_T),
    .new_hr_U  (new_hr_U),
    .new_min_T (new_min_T),
    .new_min_U (new_min_U),
    .editing   (editing),
    .sel       (sel),
    .disp_hr_T (disp_hr_T),
    .disp_hr_U (disp_hr_U),
    .disp_min_T(disp_min_T),
    .disp_min_U(disp_min_U)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_cur(input logic [15:0] v);
    {cur_hr_T, cur_hr_U, cur_min_T, cur_min_U} = v;
  endtask

  // Drive buttons for one cycle starting at a negedge.
  task automatic step(input logic e, input logic u, input logic c);
    enter_btn  = e;
    up_btn     = u;
    cancel_btn = c;
    @(negedge clk);
    enter_btn  = 1'b0;
    up_btn     = 1'b0;
    cancel_btn = 1'b0;
  endtask

  task automatic ups(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
  endtask

  // Scoreboard: each strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (set_time === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_set_time: got %h expected none", new_w);
      end else begin
        chk("commit_value", new_w, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 1, 0, 0, 0, 16'h2234};
    vecs[1] = '{16'h1959, 1, 0, 0, 0, 16'h2359};
    vecs[2] = '{16'h2359, 1, 1, 0, 0, 16'h0459};
    vecs[3] = '{16'h2359, 0, 1, 0, 0, 16'h2059};
    vecs[4] = '{16'h0959, 0, 1, 1, 1, 16'h0000};
    vecs[5] = '{16'h0000, 2, 5, 3, 7, 16'h2137};
    vecs[6] = '{16'h376B, 1, 1, 1, 1, 16'h0800};
    vecs[7] = '{16'h397C, 0, 0, 0, 0, 16'h397C};
    vecs[8] = '{16'h1248, 0, 0, 2, 3, 16'h1201};
    vecs[9] = '{16'h1500, 0, 0, 0, 0, 16'h1500};

    reset      = 1'b1;
    enter_btn  = 1'b0;
    up_btn     = 1'b0;
    cancel_btn = 1'b0;
    set_cur(16'h1234);
    repeat (2) @(negedge clk);
    chk("rst_editing", {15'b0, editing}, 16'h0);
    chk("rst_sel", {14'b0, sel}, 16'h0);
    chk("rst_set_time", {15'b0, set_time}, 16'h0);
    chk("rst_new", new_w, 16'h0000);
    chk("rst_disp", disp_w, 16'h1234);
    reset = 1'b0;
    @(negedge clk);

    // up and cancel do nothing in IDLE
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("idle_editing", {15'b0, editing}, 16'h0);
    chk("idle_new", new_w, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      set_cur(vecs[i].cur);
      step(1'b1, 1'b0, 1'b0);
      chk("capture_disp", disp_w, vecs[i].cur);
      chk("capture_editing", {15'b0, editing}, 16'h1);
      ups(vecs[i].n_ht);
      step(1'b1, 1'b0, 1'b0);
      ups(vecs[i].n_hu);
      step(1'b1, 1'b0, 1'b0);
      ups(vecs[i].n_mt);
      step(1'b1, 1'b0, 1'b0);
      ups(vecs[i].n_mu);
      chk("pre_commit_sel", {14'b0, sel}, 16'h3);
      chk("pre_commit_disp", disp_w, vecs[i].exp);
      exp_q.push_back(vecs[i].exp);
      step(1'b1, 1'b0, 1'b0);
      chk("strobe", {15'b0, set_time}, 16'h1);
      chk("commit_editing", {15'b0, editing}, 16'h0);
      @(negedge clk);
      chk("strobe_one_cycle", {15'b0, set_time}, 16'h0);
    end

    // Edit to 15:00, cur changes mid-edit, then cancel in EDIT_MT
    set_cur(16'h1400);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("mt_sel", {14'b0, sel}, 16'h2);
    chk("mt_disp", disp_w, 16'h1500);
    set_cur(16'h0909);
    step(1'b0, 1'b0, 1'b0);
    chk("frozen_disp", disp_w, 16'h1500);
    step(1'b0, 1'b0, 1'b1);
    chk("cancel_editing", {15'b0, editing}, 16'h0);
    chk("cancel_disp", disp_w, 16'h0909);

    // enter+cancel together in EDIT_HU
    set_cur(16'h1234);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("hu_sel", {14'b0, sel}, 16'h1);
    step(1'b1, 1'b0, 1'b1);
    chk("ec_editing", {15'b0, editing}, 16'h0);
    chk("ec_sel", {14'b0, sel}, 16'h0);

    // enter+up together: advances, digit unchanged
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("eu_sel", {14'b0, sel}, 16'h2);
    chk("eu_disp", disp_w, 16'h1234);
    step(1'b0, 1'b1, 1'b1);
    chk("uc_editing", {15'b0, editing}, 16'h0);

    // Timeout from EDIT_HT: idle for 8 cycles after entry
    step(1'b1, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    chk("to_before", {15'b0, editing}, 16'h1);
    @(negedge clk);
    chk("to_after", {15'b0, editing}, 16'h0);

    // A button restarts the timeout window
    step(1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    step(1'b1, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    chk("to2_before", {15'b0, editing}, 16'h1);
    chk("to2_sel", {14'b0, sel}, 16'h1);
    @(negedge clk);
    chk("to2_after", {15'b0, editing}, 16'h0);

    // Reset while the commit enter is being presented
    set_cur(16'h1234);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst2_pre_sel", {14'b0, sel}, 16'h3);
    chk("rst2_pre_disp", disp_w, 16'h2234);
    enter_btn = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rst2_async", {15'b0, editing}, 16'h0);
    @(negedge clk);
    enter_btn = 1'b0;
    chk("rst2_editing", {15'b0, editing}, 16'h0);
    chk("rst2_sel", {14'b0, sel}, 16'h0);
    chk("rst2_set_time", {15'b0, set_time}, 16'h0);
    chk("rst2_new", new_w, 16'h0000);
    chk("rst2_disp", disp_w, 16'h1234);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_idle", {15'b0, editing}, 16'h0);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
